// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: three-way register-file write arbiter.
// Starved ALU/immediate requesters take precedence over memory loads.
module regwrite_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        mem_valid,
    input  logic [3:0]  mem_index,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [3:0]  alu_index,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        imm_valid,
    input  logic [3:0]  imm_index,
    input  logic [15:0] imm_data,
    input  logic [1:0]  imm_type,
    output logic        imm_ready,
    output logic        write,
    output logic [3:0]  write_index,
    output logic [31:0] write_data
);
    logic [1:0]  alu_wait, imm_wait;
    logic        ptr_imm;
    logic        grant_en, alu_starved, imm_starved, any_starved;
    logic [31:0] imm_value;

    always_comb begin
        grant_en    = !hold && !reset;
        alu_starved = alu_valid && alu_wait == 2'd3;
        imm_starved = imm_valid && imm_wait == 2'd3;
        any_starved = alu_starved || imm_starved;
        mem_ready   = grant_en && !any_starved && mem_valid;
        alu_ready   = grant_en && (any_starved ? alu_starved && (!imm_starved || !ptr_imm)
                                               : !mem_valid && alu_valid && (!imm_valid || !ptr_imm));
        imm_ready   = grant_en && (any_starved ? imm_starved && (!alu_starved || ptr_imm)
                                               : !mem_valid && imm_valid && (!alu_valid || ptr_imm));
        imm_value   = imm_type == 2'd1 ? {{16{imm_data[15]}}, imm_data} :
                      imm_type == 2'd2 ? {imm_data, 16'h0} : {16'h0, imm_data};
    end

    // Wait counters keep counting through hold so a long hold produces starvation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_wait    <= 2'd0;
            imm_wait    <= 2'd0;
            ptr_imm     <= 1'b0;
            write       <= 1'b0;
            write_index <= 4'd0;
            write_data  <= 32'd0;
        end else begin
            alu_wait <= (!alu_valid || alu_ready) ? 2'd0 : (alu_wait == 2'd3 ? 2'd3 : alu_wait + 2'd1);
            imm_wait <= (!imm_valid || imm_ready) ? 2'd0 : (imm_wait == 2'd3 ? 2'd3 : imm_wait + 2'd1);
            ptr_imm  <= alu_ready ? 1'b1 : imm_ready ? 1'b0 : ptr_imm;
            write    <= mem_ready || alu_ready || imm_ready;
            if (mem_ready || alu_ready || imm_ready) begin
                write_index <= mem_ready ? mem_index : alu_ready ? alu_index : imm_index;
                write_data  <= mem_ready ? mem_data : alu_ready ? alu_data : imm_value;
            end
        end
    end
endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 reset  input  1  asynchronous, active-high reset.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 hold  input  1  when high, no grants are issued.
REQ-004 mem_valid, mem_index, mem_data  input  1/4/32  requester 0: memory-load writeback.
REQ-005 mem_ready  output  1  requester 0 grant.
REQ-006 alu_valid, alu_index, alu_data  input  1/4/32  requester 1: ALU writeback.
REQ-007 alu_ready  output  1  requester 1 grant.
REQ-008 imm_valid, imm_index, imm_data, imm_type  input  1/4/16/2  requester 2: immediate load.
REQ-009 imm_ready  output  1  requester 2 grant.
REQ-010 write  output  1  register-file write strobe, registered.
REQ-011 write_index  output  4  destination register, registered.
REQ-012 write_data  output  32  write value, registered.

Function
REQ-013 The *_ready outputs SHALL be combinational from the current valids, hold and internal state; at most one SHALL be high per cycle.
REQ-014 A transfer SHALL occur when valid and ready are both high at a rising clock edge.
- Requesters hold index/data stable until the transfer; the arbiter does not check this.
REQ-015 On a transfer, at that edge: write=1, write_index=granted index, write_data=granted value.
- Latency: exactly one cycle from grant to strobe.
REQ-016 In a cycle with no transfer, write SHALL be 0 at the next edge; write_index/write_data SHALL hold their last values.
REQ-017 Immediate expansion (imm_type):
- 0 unsigned: {16'h0, imm_data}
- 1 signed: sign-extend imm_data[15]
- 2 top: {imm_data, 16'h0}
- 3 reserved: treated as 0
REQ-018 Each of requesters 1 and 2 SHALL have a 2-bit wait counter:
- +1 (saturating at 3) each edge where valid=1 and not granted
- cleared on grant or when valid=0
REQ-019 A requester SHALL be "starved" when its wait counter equals 3.
REQ-020 Grant priority, highest first:
- starved requester 1/2; if both are starved, the round-robin pointer chooses
- requester 0
- non-starved requester 1/2 per the round-robin pointer
REQ-021 The round-robin pointer SHALL point to requester 1 after reset.
- After a grant to 1 it points to 2; after a grant to 2 it points to 1.
- A grant to 0 leaves it unchanged.
REQ-022 While hold=1: all ready=0, write=0 at each edge, wait counters of valid requesters still increment.
REQ-023 Same write_index on simultaneous requests SHALL be served sequentially in grant order, with no merging.
REQ-024 Back-to-back transfers SHALL be supported: one grant every cycle, no idle bubble.
REQ-025 Index 0 SHALL NOT be treated specially.

Reset
REQ-026 While reset=1:
- write=0, write_index=0, write_data=0
- all ready=0
- wait counters=0
- pointer=requester 1
REQ-027 Reset asserted mid-transfer SHALL discard the pending strobe; write SHALL be 0 from reset assertion.
REQ-028 The first grant after reset deassertion SHALL be possible on the first rising edge.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Single requester: mem_valid=1, index=5, data=32'hDEADBEEF -> mem_ready=1 same cycle; next edge write=1, write_index=5, write_data=32'hDEADBEEF; following edge write=0.
- Immediate expansion: imm_data=16'h8001 with type 0/1/2/3 -> write_data = 32'h00008001 / 32'hFFFF8001 / 32'h80010000 / 32'h00008001.
- Round-robin: alu and imm both valid continuously, mem idle -> grant order alu, imm, alu, imm; write strobe every cycle.
- Starvation: mem, alu and imm all valid continuously -> mem granted 3 cycles; alu then becomes starved and is granted in cycle 4; imm is granted within the next 4 cycles.
- Hold: all valid, hold=1 for 5 cycles -> no ready, write=0 throughout; on hold release the starved requester (alu, per pointer) is granted first.
- Reset mid-stream: reset asserted in a grant cycle -> write=0 immediately, counters and pointer at reset values; after release, an alu+imm tie grants alu.
